// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_div_op(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_core.sv
// Unsigned 64-bit shift/add (multiply) and restoring-subtract (divide) datapath with its
// iteration counter. The divide step exists only when HILO_MULDIV_DIV_EN is defined.
module hilo_muldiv_core
    import hilo_muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           run,
    input  logic           is_div,
    input  logic [W-1:0]   mag_a,
    input  logic [W-1:0]   mag_b,
    output logic [2*W-1:0] acc,
    output logic           last
);

    logic [W-1:0]   opnd;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0] acc_next;
    logic [W:0]     mul_sum;
`ifdef HILO_MULDIV_DIV_EN
    logic [W:0]     rem_shift;
    logic [W-1:0]   rem_diff;
    logic           rem_ge;
`endif

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        acc_next = acc;
        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        if (!is_div) begin
            acc_next = {mul_sum, acc[W-1:1]};
        end
`ifdef HILO_MULDIV_DIV_EN
        // Divide: acc = {partial remainder, dividend bits shifting into quotient bits}.
        rem_shift = {acc[2*W-1:W], acc[W-1]};
        rem_ge    = (rem_shift >= {1'b0, opnd});
        rem_diff  = rem_shift[W-1:0] - opnd;
        if (is_div) begin
            acc_next = rem_ge ? {rem_diff, acc[W-2:0], 1'b1}
                              : {rem_shift[W-1:0], acc[W-2:0], 1'b0};
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            opnd <= '0;
            cnt  <= '0;
        end else if (load) begin
            acc  <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
            opnd <= is_div ? mag_b : mag_a;
            cnt  <= '0;
        end else if (run) begin
            acc  <= acc_next;
            cnt  <= cnt + CNT_W'(1);
        end
    end

    assign last = run && (cnt == CNT_W'(ITER_COUNT - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO moves.
// Define HILO_MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU time out and leave HI/LO alone.
module hilo_muldiv_unit
    import hilo_muldiv_pkg::*;
#(
    parameter int ITER_BITS = 32  // only 32 is supported
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [ITER_BITS-1:0] opa,
    input  logic [ITER_BITS-1:0] opb,
    input  logic                 mthi,
    input  logic                 mtlo,
    output logic [ITER_BITS-1:0] hi,
    output logic [ITER_BITS-1:0] lo,
    output logic                 busy,
    output logic                 done
);

    localparam int W = ITER_BITS;

    state_t         state, state_next;
    op_t            op_in, op_q;
    logic           launch, a_neg, b_neg, neg_res;
    logic [W-1:0]   mag_a, mag_b;
    logic [2*W-1:0] core_acc, prod_fix;
    logic           core_last;
`ifdef HILO_MULDIV_DIV_EN
    logic           neg_rem, div_zero;
    logic [W-1:0]   opa_q, quot_fix, rem_fix;
`endif

    assign op_in  = op_t'(op);
    assign launch = (state == IDLE) && start;
    assign a_neg  = is_signed_op(op_in) && opa[W-1];
    assign b_neg  = is_signed_op(op_in) && opb[W-1];
    assign mag_a  = a_neg ? -opa : opa;
    assign mag_b  = b_neg ? -opb : opb;
    assign busy   = (state != IDLE);

    hilo_muldiv_core #(.W(W)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (launch),
        .run    (state == RUN),
        .is_div (launch ? is_div_op(op_in) : is_div_op(op_q)),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .acc    (core_acc),
        .last   (core_last)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (core_last) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == FIX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= OP_MULT;
            neg_res  <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            opa_q    <= '0;
`endif
        end else if (launch) begin
            op_q     <= op_in;
            neg_res  <= a_neg ^ b_neg;
`ifdef HILO_MULDIV_DIV_EN
            neg_rem  <= a_neg;
            div_zero <= (opb == '0);
            opa_q    <= opa;
`endif
        end
    end

    // Sign fix-up applied in FIX; the 0x80000000 / -1 case wraps naturally to 0x80000000 r 0.
    assign prod_fix = neg_res ? -core_acc : core_acc;
`ifdef HILO_MULDIV_DIV_EN
    assign quot_fix = neg_res ? -core_acc[W-1:0] : core_acc[W-1:0];
    assign rem_fix  = neg_rem ? -core_acc[2*W-1:W] : core_acc[2*W-1:W];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            if (!is_div_op(op_q)) begin
                hi <= prod_fix[2*W-1:W];
                lo <= prod_fix[W-1:0];
            end
`ifdef HILO_MULDIV_DIV_EN
            else if (div_zero) begin
                hi <= opa_q;
                lo <= '1;
            end else begin
                hi <= rem_fix;
                lo <= quot_fix;
            end
`endif
        end else if ((state == IDLE) && !start) begin
            if (mthi) hi <= opa;
            if (mtlo) lo <= opa;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit; DIV expectations follow HILO_MULDIV_DIV_EN.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.ITER_BITS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .opa   (opa),
        .opb   (opb),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation and leaves the bench in the cycle where done should be high.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        int  cycles;
        bit  done_early;
`ifndef HILO_MULDIV_DIV_EN
        if (o[1]) begin
            eh = m_hi;
            el = m_lo;
        end
`endif
        op = o; opa = a; opb = b; start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        done_early = 1'b0;
        while (busy && cycles < 40) begin
            if (done) done_early = 1'b1;
            cycles++;
            tick();
        end
        checks++;
        if (cycles !== 33) begin
            failures++;
            $display("FAIL %s busy_len: got %0d cycles expected 33", name, cycles);
        end
        checks++;
        if (done_early) begin
            failures++;
            $display("FAIL %s done_while_busy: got 1 expected 0", name);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s done_pulse: got %b expected 1", name, done);
        end
        checks++;
        if (hi !== eh || lo !== el) begin
            failures++;
            $display("FAIL %s hilo: got %h_%h expected %h_%h", name, hi, lo, eh, el);
        end
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b expected 0/0/0/0",
                     hi, lo, busy, done);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        run_op(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5");
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_single_cycle: got %b expected 0", done);
        end
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        tick();
    endtask

    task automatic test_div();
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2");
        tick();
        run_op(2'b10, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, "div_100_neg7");
        tick();
        run_op(2'b11, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, "divu_max_16");
        tick();
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_overflow");
        tick();
    endtask

    task automatic test_div_zero();
        run_op(2'b11, 32'h64, 32'h0, 32'h64, 32'hFFFFFFFF, "divu_by_zero");
        tick();
        run_op(2'b10, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_by_zero");
        tick();
    endtask

    task automatic test_back_to_back();
        run_op(2'b01, 32'd7, 32'd6, 32'h0, 32'h2A, "b2b_first");
        run_op(2'b00, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h00000000, "b2b_second");
        tick();
    endtask

    task automatic test_moves();
        opa = 32'h12345678; mthi = 1'b1;
        tick();
        mthi = 1'b0;
        checks++;
        if (hi !== 32'h12345678 || lo !== m_lo || done !== 1'b0) begin
            failures++;
            $display("FAIL mthi: got hi=%h lo=%h done=%b expected %h %h 0",
                     hi, lo, done, 32'h12345678, m_lo);
        end
        m_hi = 32'h12345678;
        opa = 32'hCAFEF00D; mtlo = 1'b1;
        tick();
        mtlo = 1'b0;
        checks++;
        if (hi !== m_hi || lo !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL mtlo: got hi=%h lo=%h expected %h %h", hi, lo, m_hi, 32'hCAFEF00D);
        end
        m_lo = 32'hCAFEF00D;
        opa = 32'hA5A5A5A5; mthi = 1'b1; mtlo = 1'b1;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        checks++;
        if (hi !== 32'hA5A5A5A5 || lo !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL mthi_mtlo: got hi=%h lo=%h expected a5a5a5a5 a5a5a5a5", hi, lo);
        end
        m_hi = 32'hA5A5A5A5;
        m_lo = 32'hA5A5A5A5;
    endtask

    task automatic test_busy_ignore();
        int cycles;
        op = 2'b01; opa = 32'd3; opb = 32'd4; start = 1'b1; mtlo = 1'b1;
        tick();
        start = 1'b0; mtlo = 1'b0;
        checks++;
        if (lo !== 32'hA5A5A5A5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_beats_move: got lo=%h busy=%b expected a5a5a5a5 1", lo, busy);
        end
        cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy) cycles++;
            tick();
        end
        op = 2'b00; opa = 32'd7; opb = 32'd7; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (busy) cycles++;
            tick();
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        checks++;
        if (hi !== 32'hA5A5A5A5 || lo !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL move_while_busy: got hi=%h lo=%h expected a5a5a5a5 a5a5a5a5", hi, lo);
        end
        while (busy && cycles < 40) begin
            cycles++;
            tick();
        end
        checks++;
        if (cycles !== 33 || done !== 1'b1 || hi !== 32'h0 || lo !== 32'hC) begin
            failures++;
            $display("FAIL start_while_busy: got cycles=%0d done=%b hilo=%h_%h expected 33 1 0_c",
                     cycles, done, hi, lo);
        end
        m_hi = 32'h0;
        m_lo = 32'hC;
        tick();
    endtask

    task automatic test_reset_mid_op();
        bit saw_done;
        bit saw_busy;
        op = 2'b00; opa = 32'hFFFFFFFD; opb = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        saw_done = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (i == 3) begin
                start = 1'b1; op = 2'b01; opa = 32'h55; mtlo = 1'b1;
            end
            if (done) saw_done = 1'b1;
            tick();
        end
        reset = 1'b0;
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_op: got hi=%h lo=%h busy=%b done=%b expected 0/0/0/0",
                     hi, lo, busy, done);
        end
        start = 1'b0; mtlo = 1'b0;
        tick();
        reset = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) saw_done = 1'b1;
            if (busy) saw_busy = 1'b1;
            tick();
        end
        checks++;
        if (saw_done || saw_busy || hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL after_reset_mid_op: got done_seen=%b busy_seen=%b hilo=%h_%h expected 0 0 0_0",
                     saw_done, saw_busy, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_moves();
        test_busy_ignore();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
